// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//
// Memory-access pipeline stage with a registered load/store unit. Sits between
// execute and writeback. One operation is accepted per upstream handshake; a
// memory operation is issued on a request/response data bus (held stable until
// the response arrives), sub-word loads are aligned and sign/zero-extended, and
// the result is held in OUT until writeback takes it.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   -> misaligned or illegal-size accesses skip
//                                      the bus, go straight to OUT with
//                                      out_misaligned = 1 and out_regwrite = 0.
//                         undefined -> illegal sizes are clamped to XLEN/8
//                                      bytes, the address low bits below the
//                                      access size are cleared, and
//                                      out_misaligned is always 0.
//
// Parameters: XLEN (32 or 64), ADDR_W.
// Ports:
//   clk, reset (async, active-low)
//   upstream  : in_valid/in_ready, in_memread, in_memwrite, in_size,
//               in_unsigned, in_addr, in_wdata, in_result, in_dst,
//               in_regwrite, flush
//   data bus  : dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_wdata,
//               dresp_ok, dresp_data
//   downstream: out_valid/out_ready, out_regdata, out_dst, out_regwrite,
//               out_skip, out_addr, out_misaligned
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_memread,
    input  logic                in_memwrite,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic [XLEN-1:0]     in_result,
    input  logic [4:0]          in_dst,
    input  logic                in_regwrite,
    input  logic                flush,
    output logic                dreq_valid,
    output logic                dreq_write,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [XLEN/8-1:0]   dreq_strobe,
    output logic [XLEN-1:0]     dreq_wdata,
    input  logic                dresp_ok,
    input  logic [XLEN-1:0]     dresp_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_regdata,
    output logic [4:0]          out_dst,
    output logic                out_regwrite,
    output logic                out_skip,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_misaligned
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Keep the low (8 << size) bits of d, then extend back to XLEN. Shifting
    // the field to the top and back keeps this generic for both XLEN values.
    function automatic logic [XLEN-1:0] extend_load(
        input logic [XLEN-1:0] d,
        input logic [1:0]      size,
        input logic            uns
    );
        logic [XLEN-1:0] up;
        logic [7:0]      sh;
        sh = 8'(XLEN) - (8'd8 << size);
        up = d << sh;
        if (uns) begin
            extend_load = up >> sh;
        end else begin
            extend_load = XLEN'($signed(up) >>> sh);
        end
    endfunction

    state_e              state_q, state_d;
    logic                kill_q, kill_d;
    logic                write_q, write_d;
    logic                load_q, load_d;
    logic                unsigned_q, unsigned_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NB-1:0]       strobe_q, strobe_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     regdata_q, regdata_d;
    logic [4:0]          dst_q, dst_d;
    logic                regwrite_q, regwrite_d;
    logic                skip_q, skip_d;
    logic                mis_q, mis_d;

    logic                accept_s;
    logic                is_mem_s;
    logic                mis_s;
    logic                go_bus_s;
    logic [1:0]          size_eff_s;
    logic [OFF_W-1:0]    lowmask_s;
    logic [ADDR_W-1:0]   addr_eff_s;
    logic [OFF_W-1:0]    off_eff_s;
    logic [NB-1:0]       strobe_base_s;
    logic [NB-1:0]       strobe_s;
    logic [XLEN-1:0]     wdata_s;
    logic [XLEN-1:0]     load_data_s;

    // Upstream handshake: a flush blocks acceptance in every state.
    assign in_ready = !flush && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_OUT) && out_ready));
    assign accept_s = in_valid && in_ready;

    // Decode the incoming operation: effective size, address, misalignment,
    // lane strobes and lane-shifted store data.
    always_comb begin
        is_mem_s = in_memread || in_memwrite;
`ifdef LSU_MISALIGN_TRAP_EN
        size_eff_s = in_size;
        lowmask_s  = ~({OFF_W{1'b1}} << in_size);
        mis_s      = is_mem_s && (((4'd1 << in_size) > 4'(NB)) ||
                                  ((in_addr[OFF_W-1:0] & lowmask_s) != {OFF_W{1'b0}}));
        addr_eff_s = in_addr;
        go_bus_s   = is_mem_s && !mis_s;
`else
        if ((4'd1 << in_size) > 4'(NB)) begin
            size_eff_s = 2'(OFF_W);
        end else begin
            size_eff_s = in_size;
        end
        lowmask_s = ~({OFF_W{1'b1}} << size_eff_s);
        mis_s     = 1'b0;
        // Only memory accesses are force-aligned; pass-through keeps its address.
        if (is_mem_s) begin
            addr_eff_s = in_addr & ~ADDR_W'(lowmask_s);
        end else begin
            addr_eff_s = in_addr;
        end
        go_bus_s = is_mem_s;
`endif
        off_eff_s     = addr_eff_s[OFF_W-1:0];
        strobe_base_s = ~({NB{1'b1}} << (4'd1 << size_eff_s));
        if (in_memwrite) begin
            strobe_s = strobe_base_s << off_eff_s;
        end else begin
            strobe_s = {NB{1'b1}};
        end
        wdata_s = in_wdata << {off_eff_s, 3'b000};
    end

    // Right-justify the response word for the registered lane, then extend.
    assign load_data_s = extend_load(dresp_data >> {addr_q[OFF_W-1:0], 3'b000},
                                     size_q, unsigned_q);

    // Next-state and capture logic for the IDLE/BUS/OUT controller.
    always_comb begin
        state_d    = state_q;
        kill_d     = 1'b0;
        write_d    = write_q;
        load_d     = load_q;
        unsigned_d = unsigned_q;
        size_d     = size_q;
        addr_d     = addr_q;
        strobe_d   = strobe_q;
        wdata_d    = wdata_q;
        regdata_d  = regdata_q;
        dst_d      = dst_q;
        regwrite_d = regwrite_q;
        skip_d     = skip_q;
        mis_d      = mis_q;

        if (accept_s) begin
            write_d    = in_memwrite;
            load_d     = in_memread;
            unsigned_d = in_unsigned;
            size_d     = size_eff_s;
            addr_d     = addr_eff_s;
            strobe_d   = strobe_s;
            wdata_d    = wdata_s;
            regdata_d  = in_result;
            dst_d      = in_dst;
            regwrite_d = in_regwrite && !mis_s;
            skip_d     = is_mem_s;
            mis_d      = mis_s;
        end else begin
            regdata_d = regdata_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = go_bus_s ? ST_BUS : ST_OUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                // The bus transaction always completes; a flush only
                // suppresses the OUT cycle that would follow it.
                if (dresp_ok) begin
                    state_d = (kill_q || flush) ? ST_IDLE : ST_OUT;
                    if (load_q) begin
                        regdata_d = load_data_s;
                    end else begin
                        regdata_d = regdata_q;
                    end
                end else begin
                    kill_d  = kill_q || flush;
                    state_d = ST_BUS;
                end
            end
            ST_OUT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    if (accept_s) begin
                        state_d = go_bus_s ? ST_BUS : ST_OUT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and operation registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            kill_q     <= 1'b0;
            write_q    <= 1'b0;
            load_q     <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= {ADDR_W{1'b0}};
            strobe_q   <= {NB{1'b0}};
            wdata_q    <= {XLEN{1'b0}};
            regdata_q  <= {XLEN{1'b0}};
            dst_q      <= 5'd0;
            regwrite_q <= 1'b0;
            skip_q     <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            write_q    <= write_d;
            load_q     <= load_d;
            unsigned_q <= unsigned_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            strobe_q   <= strobe_d;
            wdata_q    <= wdata_d;
            regdata_q  <= regdata_d;
            dst_q      <= dst_d;
            regwrite_q <= regwrite_d;
            skip_q     <= skip_d;
            mis_q      <= mis_d;
        end
    end

    assign dreq_valid     = (state_q == ST_BUS);
    assign dreq_write     = (state_q == ST_BUS) && write_q;
    assign dreq_addr      = addr_q;
    assign dreq_strobe    = strobe_q;
    assign dreq_wdata     = wdata_q;
    assign out_valid      = (state_q == ST_OUT);
    assign out_regdata    = regdata_q;
    assign out_dst        = dst_q;
    assign out_regwrite   = regwrite_q;
    assign out_skip       = skip_q;
    assign out_addr       = addr_q;
    assign out_misaligned = mis_q;

endmodule
